// File: rtl/pulse_train_pkg.sv
// -----------------------------------------------------------------------------
// pulse_train_pkg
// Shared definitions for the pulse train generator:
//   - state_t : FSM state encoding (IDLE, HIGH, LOW, GAP)
//   - PTG_CNT_W_DEF / PTG_SET_W_DEF : default field widths
// Optional build macro affecting the block: PULSE_TRAIN_GEN_ABORT_EN
// -----------------------------------------------------------------------------
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int PTG_CNT_W_DEF = 8;
  localparam int PTG_SET_W_DEF = 4;

endpackage

// File: rtl/ptg_down_counter.sv
// -----------------------------------------------------------------------------
// ptg_down_counter
// Loadable down counter used as the phase timer. Load has priority; otherwise
// the count decrements until it reaches zero and then holds there.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset (count -> 0)
//   i_load     : load i_load_val on the next edge
//   i_load_val : value to load
//   o_zero     : count is zero (current phase is in its last cycle)
// -----------------------------------------------------------------------------
module ptg_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// Generates trains of pulses: each train is cfg_sets sets, each set is
// cfg_pulses pulses of (high_len high, low_len low) followed by gap_len idle
// cycles. A train starts on a rising edge of trigger seen while idle.
//
// Protocol: a trigger rising edge sampled at edge k (while idle and not on the
// busy/done tail of a previous train) latches cfg_* and starts a train; pulse
// and busy rise from edge k+1. busy stays high for the whole train; done is a
// one-cycle strobe in the first cycle after busy falls. Trigger edges seen
// while busy or done are dropped, not queued.
//
// Ports:
//   clk, reset_n        : clock / asynchronous active-low reset
//   trigger             : train start request (rising-edge detected)
//   cfg_high_len/low_len/gap_len/pulses (CNT_W), cfg_sets (SET_W)
//   cfg_continuous      : sampled at end of the final set; 1 = restart train
//   abort               : only with PULSE_TRAIN_GEN_ABORT_EN; forces idle
//   pulse, busy, done   : registered outputs
//   set_idx             : 0-based index of the current set
//   dbg_state           : FSM state, for observation
// Optional build macro: PULSE_TRAIN_GEN_ABORT_EN
// -----------------------------------------------------------------------------
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = PTG_CNT_W_DEF,
  parameter int SET_W = PTG_SET_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic [CNT_W-1:0] cfg_high_len,
  input  logic [CNT_W-1:0] cfg_low_len,
  input  logic [CNT_W-1:0] cfg_gap_len,
  input  logic [CNT_W-1:0] cfg_pulses,
  input  logic [SET_W-1:0] cfg_sets,
  input  logic             cfg_continuous,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [SET_W-1:0] set_idx,
  output state_t           dbg_state
);

  function automatic logic [CNT_W-1:0] nz_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [SET_W-1:0] nz_set(input logic [SET_W-1:0] v);
    return (v == '0) ? SET_W'(1) : v;
  endfunction

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_high, r_low, r_gap, r_pulses;
  logic [SET_W-1:0] r_sets;
  logic [CNT_W-1:0] r_pidx, w_pidx_nxt;
  logic [SET_W-1:0] r_sidx, w_sidx_nxt;
  logic             r_trig_q, r_armed;
  logic             r_pulse, r_busy, r_done;
  logic [SET_W-1:0] r_set_o;
  logic             w_ld, w_zero, w_start, w_set_end, w_trig_edge;
  logic [CNT_W-1:0] w_ld_val;

  // r_armed is cleared by reset and set once trigger is seen low, so a
  // trigger held through reset release cannot masquerade as a fresh edge.
  assign w_trig_edge = trigger & ~r_trig_q & r_armed;

  ptg_down_counter #(.W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_ld       = 1'b0;
    w_ld_val   = '0;
    w_pidx_nxt = r_pidx;
    w_sidx_nxt = r_sidx;
    w_start    = 1'b0;
    w_set_end  = 1'b0;
    case (r_state)
      IDLE: begin
        // r_busy/r_done still high means we are on the tail of a train.
        if (w_trig_edge && !r_busy && !r_done) begin
          w_start    = 1'b1;
          w_next     = HIGH;
          w_ld       = 1'b1;
          w_ld_val   = nz_cnt(cfg_high_len) - 1'b1;
          w_pidx_nxt = '0;
          w_sidx_nxt = '0;
        end
      end
      HIGH: begin
        if (w_zero) begin
          w_next   = LOW;
          w_ld     = 1'b1;
          w_ld_val = r_low - 1'b1;
        end
      end
      LOW: begin
        if (w_zero) begin
          if (r_pidx == r_pulses - 1'b1) begin
            if (r_gap != '0) begin
              w_next   = GAP;
              w_ld     = 1'b1;
              w_ld_val = r_gap - 1'b1;
            end else begin
              w_set_end = 1'b1;
            end
          end else begin
            w_next     = HIGH;
            w_ld       = 1'b1;
            w_ld_val   = r_high - 1'b1;
            w_pidx_nxt = r_pidx + 1'b1;
          end
        end
      end
      GAP: begin
        if (w_zero) begin
          w_set_end = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase

    if (w_set_end) begin
      w_pidx_nxt = '0;
      if (r_sidx == r_sets - 1'b1) begin
        w_sidx_nxt = '0;
        if (cfg_continuous) begin
          w_next   = HIGH;
          w_ld     = 1'b1;
          w_ld_val = r_high - 1'b1;
        end else begin
          w_next = IDLE;
        end
      end else begin
        w_sidx_nxt = r_sidx + 1'b1;
        w_next     = HIGH;
        w_ld       = 1'b1;
        w_ld_val   = r_high - 1'b1;
      end
    end

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    if (abort) begin
      w_start    = 1'b0;
      w_next     = IDLE;
      w_ld       = 1'b1;
      w_ld_val   = '0;
      w_pidx_nxt = '0;
      w_sidx_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_pidx   <= '0;
      r_sidx   <= '0;
      r_trig_q <= 1'b0;
      r_armed  <= 1'b0;
      r_high   <= '0;
      r_low    <= '0;
      r_gap    <= '0;
      r_pulses <= '0;
      r_sets   <= '0;
    end else begin
      r_state  <= w_next;
      r_pidx   <= w_pidx_nxt;
      r_sidx   <= w_sidx_nxt;
      r_trig_q <= trigger;
      if (!trigger) begin
        r_armed <= 1'b1;
      end
      if (w_start) begin
        r_high   <= nz_cnt(cfg_high_len);
        r_low    <= nz_cnt(cfg_low_len);
        r_gap    <= cfg_gap_len;
        r_pulses <= nz_cnt(cfg_pulses);
        r_sets   <= nz_set(cfg_sets);
      end
    end
  end

  // Outputs are registered copies of the state, so they trail the FSM by one
  // cycle; done fires the cycle after the last busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_set_o <= '0;
    end
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    else if (abort) begin
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_set_o <= '0;
    end
`endif
    else begin
      r_pulse <= (r_state == HIGH);
      r_busy  <= (r_state != IDLE);
      r_done  <= (r_state == IDLE) && r_busy;
      r_set_o <= r_sidx;
    end
  end

  assign pulse     = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign set_idx   = r_set_o;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
// Self-checking bench for pulse_train_gen. Expected per-cycle output words
// {pulse, busy, done, set_idx} are computed from the train formula when the
// stimulus is driven and compared cycle by cycle at the falling clock edge.
// Optional build macro exercised: PULSE_TRAIN_GEN_ABORT_EN
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;
  import pulse_train_pkg::*;

  localparam int CNT_W = 8;
  localparam int SET_W = 4;
  localparam int EXP_W = 3 + SET_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             trigger = 1'b0;
  logic [CNT_W-1:0] cfg_high_len = '0, cfg_low_len = '0, cfg_gap_len = '0, cfg_pulses = '0;
  logic [SET_W-1:0] cfg_sets = '0;
  logic             cfg_continuous = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             pulse, busy, done;
  logic [SET_W-1:0] set_idx;
  state_t           dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  pulse_train_gen #(.CNT_W(CNT_W), .SET_W(SET_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trigger        (trigger),
    .cfg_high_len   (cfg_high_len),
    .cfg_low_len    (cfg_low_len),
    .cfg_gap_len    (cfg_gap_len),
    .cfg_pulses     (cfg_pulses),
    .cfg_sets       (cfg_sets),
    .cfg_continuous (cfg_continuous),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort          (abort),
`endif
    .pulse          (pulse),
    .busy           (busy),
    .done           (done),
    .set_idx        (set_idx),
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int h, input int l, input int g, input int p, input int s);
    cfg_high_len = CNT_W'(h);
    cfg_low_len  = CNT_W'(l);
    cfg_gap_len  = CNT_W'(g);
    cfg_pulses   = CNT_W'(p);
    cfg_sets     = SET_W'(s);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  // Expected words for one train; arguments are effective (nonzero) lengths.
  task automatic push_train(input int h, input int l, input int g, input int p,
                            input int s, input bit with_done);
    int per_set;
    logic pl;
    per_set = p * (h + l) + g;
    for (int t = 0; t < s * per_set; t++) begin
      pl = ((t % per_set) < p * (h + l)) && (((t % per_set) % (h + l)) < h);
      exp_q.push_back({pl, 1'b1, 1'b0, SET_W'(t / per_set)});
    end
    if (with_done) exp_q.push_back({1'b0, 1'b0, 1'b1, SET_W'(0)});
  endtask

  task automatic settle_idle;
    trigger = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [EXP_W-1:0] got;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", pulse); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++;
    if (set_idx !== '0) $display("FAIL reset_set_idx: got %0d want 0", set_idx); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {pulse, busy, done, set_idx};
    n_checks++;
    if (got !== '0) $display("FAIL reset_release_idle: got %b want 0000000", got); else n_pass++;
  endtask

  task automatic test_basic;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(2, 1, 4, 3, 2);
    trigger = 1'b1;
    push_idle(1);
    push_train(2, 1, 4, 3, 2, 1'b1);
    push_idle(3);
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL basic c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL basic c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 1) trigger = 1'b0;
      if (c == 3) set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 15));
    end
  endtask

  task automatic test_zero_cfg;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(0, 0, 0, 0, 0);
    trigger = 1'b1;
    push_idle(1);
    push_train(1, 1, 0, 1, 1, 1'b1);
    push_idle(4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL zero_cfg c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL zero_cfg c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 0) trigger = 1'b0;
    end
  endtask

  task automatic test_continuous;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(1, 1, 1, 1, 2);
    cfg_continuous = 1'b1;
    trigger = 1'b1;
    push_idle(1);
    push_train(1, 1, 1, 1, 2, 1'b0);
    push_train(1, 1, 1, 1, 2, 1'b1);
    push_idle(3);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL continuous c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL continuous c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 0) trigger = 1'b0;
      if (c == 9) cfg_continuous = 1'b0;
    end
  endtask

  // Trigger edges landing on the busy tail and on the done cycle are dropped.
  task automatic test_back_to_back;
    logic [EXP_W-1:0] got, exp;
    for (int pass = 0; pass < 2; pass++) begin
      settle_idle();
      set_cfg(0, 0, 0, 0, 0);
      trigger = 1'b1;
      push_idle(1);
      push_train(1, 1, 0, 1, 1, 1'b1);
      push_idle(6);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        got = {pulse, busy, done, set_idx};
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL back_to_back%0d c=%0d: no expected entry, got %b", pass, c, got);
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) $display("FAIL back_to_back%0d c=%0d: got p/b/d/idx %b want %b", pass, c, got, exp);
          else n_pass++;
        end
        if (c == 0) trigger = 1'b0;
        if (c == 2 + pass) trigger = 1'b1;
        if (c == 6) trigger = 1'b0;
      end
    end
  endtask

  task automatic test_level_hold;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(2, 1, 4, 3, 2);
    trigger = 1'b1;
    push_idle(1);
    push_train(2, 1, 4, 3, 2, 1'b1);
    push_idle(14);
    for (int c = 0; c < 47; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL level_hold c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL level_hold c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 39) trigger = 1'b0;
      if (c == 41) begin
        set_cfg(0, 0, 0, 0, 0);
        trigger = 1'b1;
        push_idle(1);
        push_train(1, 1, 0, 1, 1, 1'b1);
        push_idle(1);
      end
    end
    trigger = 1'b0;
  endtask

  task automatic test_midtrain_reset;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(2, 1, 4, 3, 2);
    trigger = 1'b1;
    push_idle(1);
    push_train(2, 1, 4, 3, 2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL midreset_pre c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL midreset_pre c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    got = {pulse, busy, done, set_idx};
    n_checks++;
    if (got !== '0) $display("FAIL midreset_async: got p/b/d/idx %b want 0000000", got); else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL midreset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_idle(8);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL midreset_held c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL midreset_held c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
    end
    trigger = 1'b0;
    push_idle(1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL midreset_fresh c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL midreset_fresh c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 0) begin
        set_cfg(0, 0, 0, 0, 0);
        trigger = 1'b1;
        push_idle(1);
        push_train(1, 1, 0, 1, 1, 1'b1);
        push_idle(1);
      end
    end
    trigger = 1'b0;
  endtask

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  task automatic test_abort;
    logic [EXP_W-1:0] got, exp;
    settle_idle();
    set_cfg(2, 1, 4, 3, 2);
    trigger = 1'b1;
    push_idle(1);
    push_train(2, 1, 4, 3, 2, 1'b1);
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      got = {pulse, busy, done, set_idx};
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL abort c=%0d: no expected entry, got %b", c, got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL abort c=%0d: got p/b/d/idx %b want %b", c, got, exp);
        else n_pass++;
      end
      if (c == 0) trigger = 1'b0;
      if (c == 10) begin
        // FSM is in GAP here; abort and a fresh trigger edge land together.
        exp_q.delete();
        push_idle(10);
        abort   = 1'b1;
        trigger = 1'b1;
      end
      if (c == 11) abort = 1'b0;
    end
    trigger = 1'b0;
  endtask
`endif

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_cfg();
    test_continuous();
    test_back_to_back();
    test_level_hold();
    test_midtrain_reset();
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    test_abort();
`endif
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of high/low/gap length and pulses-per-set fields.
REQ-002 SHALL have parameter SET_W, default 4, width of sets-per-train field and set index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port trigger  input  1  train start request, rising-edge detected.
REQ-006 SHALL have ports cfg_high_len, cfg_low_len, cfg_gap_len, cfg_pulses  input  CNT_W each  high cycles, low cycles, inter-set gap cycles, pulses per set.
REQ-007 SHALL have port cfg_sets  input  SET_W  sets per train.
REQ-008 SHALL have port cfg_continuous  input  1  repeat train until cleared.
REQ-009 SHALL have port pulse  output  1  registered pulse train.
REQ-010 SHALL have port busy  output  1  high while a train is active.
REQ-011 SHALL have port done  output  1  one-cycle strobe at train completion.
REQ-012 SHALL have port set_idx  output  SET_W  index of the current set, 0-based.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW, GAP.
REQ-014 SHALL detect a trigger rising edge using a registered copy of trigger; level-high trigger SHALL NOT retrigger.
REQ-015 SHALL, on an edge detected in IDLE at edge k, latch all cfg_* inputs and enter HIGH, with pulse=1 and busy=1 from edge k+1.
REQ-016 SHALL ignore cfg_* changes while busy, except cfg_continuous, which is sampled at end of the final set.
REQ-017 SHALL treat zero high_len, low_len, pulses or sets as 1; gap_len 0 SHALL skip GAP.
REQ-018 SHALL hold HIGH for high_len cycles, then LOW for low_len cycles, per pulse.
REQ-019 SHALL, after the LOW of the last pulse of a set, enter GAP for gap_len cycles, then either HIGH of the next set (set_idx+1) or end of train.
REQ-020 SHALL, at end of train with cfg_continuous=0, return to IDLE, drop busy, and assert done for exactly one cycle.
REQ-021 SHALL, at end of train with cfg_continuous=1, wrap set_idx to 0 and re-enter HIGH with no idle cycle and no done.
REQ-022 SHALL drive pulse=1 only in HIGH.
REQ-023 SHALL ignore trigger edges while busy, including on the done cycle.
REQ-024 SHALL make total train length equal to sets*(pulses*(high+low)+gap) cycles.
REQ-025 SHALL use saturating-free counters sized CNT_W/SET_W; no overflow is possible within legal ranges.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force IDLE, pulse=0, busy=0, done=0, set_idx=0, counters=0, trigger history=0.
REQ-027 SHALL, on reset mid-train, abandon the train without asserting done; an asserted trigger at release SHALL NOT start a train until a fresh rising edge.

Configuration
REQ-028 SHALL, with PULSE_TRAIN_GEN_ABORT_EN defined, add input abort (1 bit); abort=1 at any edge SHALL force IDLE next cycle with pulse=0, busy=0, done=0, set_idx=0, and abort SHALL take priority over trigger.
REQ-029 SHALL, without PULSE_TRAIN_GEN_ABORT_EN, omit the abort port and its logic entirely.

Structure
REQ-030 SHALL place the state enumeration typedef and default parameter constants in package pulse_train_pkg.
REQ-031 SHALL use one sub-module, ptg_down_counter (load/decrement/zero flag, parametrised width), instantiated for the phase timer; pulse and set counters SHALL live in the top.

Verification
REQ-032 SHALL cover: high=2, low=1, pulses=3, sets=2, gap=4, trigger edge at cycle 0 -> pulse high cycles 1-2, 4-5, 7-8, 14-15, 17-18, 20-21; done at cycle 27; busy cycles 1-26.
REQ-033 SHALL cover: all cfg=0 -> single 1-cycle high, 1-cycle low, done at cycle 3.
REQ-034 SHALL cover: cfg_continuous=1 for two trains, then cleared during the 2nd train -> no gap between trains, set_idx wraps 1->0, one done after 2nd train only.
REQ-035 SHALL cover: trigger held high 40 cycles with 26-cycle train -> exactly one train; fresh edge after done starts the next.
REQ-036 SHALL cover: reset_n low at cycle 10 of a train -> pulse/busy 0 immediately, no done, idle after release.
REQ-037 SHALL cover, with PULSE_TRAIN_GEN_ABORT_EN: abort during GAP together with trigger edge -> IDLE next cycle, no done, no restart.
